// File: rtl/ram_burst_reader.sv
// Burst read initiator: walks a combinational RAM read port over consecutive addresses
// and presents the words as a valid/ready stream, one word per cycle when unstalled.
module ram_burst_reader #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [LEN_WIDTH-1:0]  length_i,
  input  logic                  abort_i,
  output logic [ADDR_WIDTH-1:0] r_addr_o,
  input  logic [DATA_WIDTH-1:0] ram_data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  issue_q, issue_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      len_q   <= '0;
      issue_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      len_q   <= len_d;
      issue_q <= issue_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    len_d   = len_q;
    issue_d = issue_q;

    unique case (state_q)
      StIdle, StDone: begin
        valid_d = 1'b0;
        state_d = StIdle;
        if (start_i) begin
          addr_d  = base_addr_i;
          len_d   = length_i;
          issue_d = '0;
          state_d = StRead;
        end
      end
      StRead: begin
        // A zero-length burst spends one busy cycle here without reading.
        if (issue_q == len_q) begin
          state_d = StDone;
        end else if (!valid_q || ready_i) begin
          data_d  = ram_data_i;
          valid_d = 1'b1;
          addr_d  = addr_q + 1'b1;
          issue_d = issue_q + 1'b1;
          if ((issue_q + 1'b1) == len_q) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (ready_i) begin
          valid_d = 1'b0;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase

    if (abort_i && (state_q == StRead || state_q == StDrain)) begin
      state_d = StIdle;
      valid_d = 1'b0;
    end
  end

  assign r_addr_o = addr_q;
  assign data_o   = data_q;
  assign valid_o  = valid_q;
  assign busy_o   = (state_q == StRead) || (state_q == StDrain);
  assign done_o   = (state_q == StDone);

endmodule
